// File: rtl/pwm_config_scheduler.sv
// Double-buffered configuration scheduler for NCH PWM timers: writes land in a
// per-channel shadow set and are committed to the active set at a safe point.
module pwm_config_scheduler #(
   parameter  int NCH = 4,
   parameter  int W   = 16,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WrValid,
   output logic              WrReady,
   input  logic [CW-1:0]     WrChan,
   input  logic [1:0]        WrReg,
   input  logic [W-1:0]      WrData,
   input  logic [NCH-1:0]    PeriodEnd,
   output logic [NCH*W-1:0]  Prescaler,
   output logic [NCH*W-1:0]  Count,
   output logic [NCH*W-1:0]  SwitchValue,
   output logic [NCH-1:0]    Enable,
   output logic [NCH-1:0]    Pending,
   output logic [NCH-1:0]    UpdateDone
);

   typedef enum logic {ST_IDLE, ST_ARMED} state_t;

   logic r_ready_en;
   logic w_blocked;
   logic w_accept;

   // Shadow writes to an armed channel stall so the committed set stays coherent.
   always_comb begin
      w_blocked = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (WrChan == CW'(c) && Pending[c] && WrReg != 2'd3)
            w_blocked = 1'b1;
      end
   end

   assign WrReady  = r_ready_en & ~w_blocked;
   assign w_accept = WrValid & WrReady;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_ready_en <= 1'b0;
      else     r_ready_en <= 1'b1;
   end

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         state_t         r_state;
         state_t         w_state_next;
         logic [W-1:0]   r_sh_ps, r_sh_ct, r_sh_sv;
         logic [W-1:0]   r_ps, r_ct, r_sv;
         logic           r_en;
         logic           r_done;
         logic           w_sel;
         logic           w_ctrl;
         logic           w_arm;
         logic           w_commit;

         assign w_sel  = w_accept && (WrChan == CW'(gi));
         assign w_ctrl = w_sel && (WrReg == 2'd3);
         assign w_arm  = w_ctrl && WrData[1];

         // A disabled channel has no period boundary to wait for, so it commits at once.
         always_comb begin
            w_state_next = r_state;
            w_commit     = 1'b0;
            case (r_state)
               ST_IDLE: begin
                  if (w_arm) w_state_next = ST_ARMED;
               end
               ST_ARMED: begin
                  if (!r_en || PeriodEnd[gi]) begin
                     w_commit     = 1'b1;
                     w_state_next = w_arm ? ST_ARMED : ST_IDLE;
                  end
               end
               default: w_state_next = ST_IDLE;
            endcase
         end

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) r_state <= ST_IDLE;
            else     r_state <= w_state_next;
         end

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               r_sh_ps <= '0;
               r_sh_ct <= '0;
               r_sh_sv <= '0;
               r_ps    <= '0;
               r_ct    <= '0;
               r_sv    <= '0;
               r_en    <= 1'b0;
               r_done  <= 1'b0;
            end else begin
               r_done <= w_commit;
               if (w_commit) begin
                  r_ps <= r_sh_ps;
                  r_ct <= r_sh_ct;
                  r_sv <= r_sh_sv;
               end
               if (w_sel) begin
                  case (WrReg)
                     2'd0:    r_sh_ps <= WrData;
                     2'd1:    r_sh_ct <= WrData;
                     2'd2:    r_sh_sv <= WrData;
                     default: r_en    <= WrData[0];
                  endcase
               end
            end
         end

         assign Prescaler[gi*W +: W]   = r_ps;
         assign Count[gi*W +: W]       = r_ct;
         assign SwitchValue[gi*W +: W] = r_sv;
         assign Enable[gi]             = r_en;
         assign Pending[gi]            = (r_state == ST_ARMED);
         assign UpdateDone[gi]         = r_done;
      end
   endgenerate

endmodule

// File: doc/pwm_config_scheduler.md
PWM_CONFIG_SCHEDULER -- requirements
Module: pwm_config_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4: number of timer channels served (2..8).
REQ-002 SHALL have parameter W, default 16: width of the prescaler, period and switch values.
REQ-003 SHALL have port CLK  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  in  1: reset, asynchronous and active-high.
REQ-005 SHALL have port WrValid  in  1: write request valid.
REQ-006 SHALL have port WrReady  out  1: write accepted when WrValid and WrReady are both high at a rising edge.
REQ-007 SHALL have port WrChan  in  clog2(NCH): target channel; values >= NCH are accepted and ignored.
REQ-008 SHALL have port WrReg  in  2: register select; 0 = Prescaler, 1 = Count, 2 = SwitchValue, 3 = Control.
REQ-009 SHALL have port WrData  in  W: write data; Control uses bit0 = enable and bit1 = arm.
REQ-010 SHALL have port PeriodEnd  in  NCH: one-cycle pulse per channel, high when that timer's counter wraps.
REQ-011 SHALL have ports Prescaler, Count, SwitchValue  out  NCH*W each: active values, channel c at bits [c*W +: W].
REQ-012 SHALL have port Enable  out  NCH: channel run enable, driving the timer's active-low reset.
REQ-013 SHALL have port Pending  out  NCH: channel armed with a commit outstanding.
REQ-014 SHALL have port UpdateDone  out  NCH: one-cycle pulse in the cycle after a commit.

Function
REQ-015 SHALL hold per channel a shadow set (Prescaler, Count, SwitchValue) and an active set; only the active set drives outputs.
REQ-016 SHALL give each channel a two-state FSM, IDLE (Pending=0) and ARMED (Pending=1).
REQ-017 SHALL, on an accepted write with WrReg 0..2, update only the shadow field of WrChan, in the same edge.
REQ-018 SHALL, on an accepted Control write, set Enable[WrChan]=WrData[0] at that edge; if WrData[1]=1, the channel goes IDLE->ARMED.
REQ-019 SHALL hold WrReady low when WrReg is 0..2 and Pending[WrChan]=1 (shadow locked while armed); Control writes are never stalled.
REQ-020 SHALL commit an ARMED channel with Enable=1 at the first PeriodEnd[c]=1 edge: active <= shadow, state -> IDLE.
REQ-021 SHALL commit an ARMED channel with Enable=0 on the edge after arming, independent of PeriodEnd.
REQ-022 SHALL ignore PeriodEnd[c] while the channel is IDLE; no output change occurs.
REQ-023 SHALL pulse UpdateDone[c] high for exactly one cycle after each commit; a re-arm in that cycle is legal and is not merged.
REQ-024 SHALL handle an arm write landing on the same edge as PeriodEnd[c] on an IDLE channel as follows: the channel arms, no commit occurs on that edge, and it waits for the next PeriodEnd.
REQ-025 SHALL, on a Control write to an ARMED channel with arm=0, leave it ARMED; with arm=1, keep it ARMED with no duplicate commit.
REQ-026 SHALL, on a Control write setting Enable 1->0 while ARMED, commit on the following edge per REQ-021.
REQ-027 SHALL allow independent channels to commit on the same edge; no arbitration is needed between commits.
REQ-028 SHALL give the write path single-cycle latency: accepted data is visible in the shadow on the next cycle.
REQ-029 SHALL copy values verbatim with no width conversion; the scheduler performs no range check (Count=0 is legal).

Reset
REQ-030 SHALL, while RST=1, asynchronously clear all shadow and active fields to 0, Enable to 0, Pending to 0 and UpdateDone to 0, and force WrReady to 0.
REQ-031 SHALL, after RST falls, set WrReady=1 on the first edge; an armed commit pending at reset is discarded.

Verification
REQ-032 SHALL pass this test: on ch0 write Prescaler=3, Count=99, SwitchValue=25, then Control=3 with no PeriodEnd -> active stays 0, Pending[0]=1; pulse PeriodEnd[0] -> active 3/99/25 next cycle, UpdateDone[0] for one cycle.
REQ-033 SHALL pass this test: arm ch1 with Enable=0, SwitchValue=7 -> commit on the next edge with no PeriodEnd needed, Pending[1]=0.
REQ-034 SHALL pass this test: ch2 armed, then WrValid with WrReg=1 to ch2 -> WrReady=0 until PeriodEnd[2] commits, then the write is accepted into the shadow only.
REQ-035 SHALL pass this test: arm ch3 on the same edge as PeriodEnd[3] -> no commit; the next PeriodEnd[3] commits.
REQ-036 SHALL pass this test: ch0 and ch1 both armed, PeriodEnd=4'b0011 -> both commit on the same edge, UpdateDone=4'b0011.
REQ-037 SHALL pass this test: assert RST mid-ARMED on ch0 -> all outputs 0 immediately and no commit after release.
